// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared state encoding and operand/PC select codes
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        MEM_WAIT   = 2'd1,
        TRAP_DRAIN = 2'd2
    } state_t;

    localparam logic [1:0] FWD_LATCH = 2'd0;
    localparam logic [1:0] FWD_MEM   = 2'd1;
    localparam logic [1:0] FWD_WB    = 2'd2;

    localparam logic [1:0] PCSEL_PC4    = 2'd0;
    localparam logic [1:0] PCSEL_BRANCH = 2'd1;
    localparam logic [1:0] PCSEL_TRAP   = 2'd2;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd.sv
// fwd_unit: picks the freshest producer of one EX source operand
module fwd_unit
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rd_mem,
    input  logic       we_mem,
    input  logic [4:0] rd_wb,
    input  logic       we_wb,
    output logic [1:0] fwd
);

    logic hit_mem;
    logic hit_wb;

    assign hit_mem = we_mem && rd_mem != 5'd0 && rd_mem == rs;
    assign hit_wb  = we_wb && rd_wb != 5'd0 && rd_wb == rs;

    // EX/MEM holds the younger result, so it wins over MEM/WB
    always_comb fwd = hit_mem ? FWD_MEM : hit_wb ? FWD_WB : FWD_LATCH;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/redirect control and forwarding for a 5-stage pipeline
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1_ID,
    input  logic [4:0]  rs2_ID,
    input  logic        rs1_used_ID,
    input  logic        rs2_used_ID,
    input  logic [4:0]  rd_EX,
    input  logic        RegWrite_EX,
    input  logic        mem_r_EX,
    input  logic [4:0]  rd_MEM,
    input  logic        RegWrite_MEM,
    input  logic [4:0]  rs1_EX,
    input  logic [4:0]  rs2_EX,
    input  logic        branch_taken_EX,
    input  logic        trap_MEM,
    input  logic        mret_MEM,
    input  logic        dmem_req,
    input  logic        dmem_ack,
    input  logic [4:0]  rd_WB,
    input  logic        RegWrite_WB,
    output logic        en_PC,
    output logic        en_IFID,
    output logic        en_IDEX,
    output logic        en_EXMEM,
    output logic        flush_IFID,
    output logic        flush_IDEX,
    output logic        flush_EXMEM,
    output logic [1:0]  fwd_A,
    output logic [1:0]  fwd_B,
    output logic [1:0]  pc_sel,
    output logic [31:0] stall_cnt
);

    state_t     state;
    state_t     state_n;
    logic       freeze;
    logic       trap;
    logic       load_use;
    logic [1:0] fwd_a_raw;
    logic [1:0] fwd_b_raw;

    // in MEM_WAIT only the ack releases the freeze; elsewhere a fresh unacked request starts one
    assign freeze   = (state == MEM_WAIT) ? !dmem_ack : (dmem_req && !dmem_ack);
    assign trap     = trap_MEM || mret_MEM;
    assign load_use = mem_r_EX && RegWrite_EX && rd_EX != 5'd0 &&
                      ((rs1_used_ID && rs1_ID == rd_EX) || (rs2_used_ID && rs2_ID == rd_EX));

    // state register; reset abandons any wait or drain in progress
    always_ff @(posedge clk) begin
        state <= rst ? RUN : state_n;
    end

    // next state: freeze dominates, a trap outside the drain cycle enters the drain
    always_comb begin
        state_n = RUN;
        if (freeze)
            state_n = MEM_WAIT;
        else if (state != TRAP_DRAIN && trap)
            state_n = TRAP_DRAIN;
    end

    // outputs: reset and freeze force everything idle, otherwise trap > branch > load-use
    always_comb begin
        {en_PC, en_IFID, en_IDEX, en_EXMEM} = 4'b0000;
        {flush_IFID, flush_IDEX, flush_EXMEM} = 3'b000;
        pc_sel = PCSEL_PC4;
        if (!rst && !freeze) begin
            {en_PC, en_IFID, en_IDEX, en_EXMEM} = 4'b1111;
            if (state == TRAP_DRAIN) begin
                flush_IFID = 1'b1;
            end else if (trap) begin
                pc_sel = PCSEL_TRAP;
                {flush_IFID, flush_IDEX, flush_EXMEM} = 3'b111;
            end else if (branch_taken_EX) begin
                pc_sel = PCSEL_BRANCH;
                {flush_IFID, flush_IDEX} = 2'b11;
            end else if (load_use) begin
                {en_PC, en_IFID} = 2'b00;
                flush_IDEX = 1'b1;
            end
        end
    end

    // stall counter counts every non-reset cycle with the PC held; wraps naturally
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= 32'd0;
        else if (!en_PC)
            stall_cnt <= stall_cnt + 32'd1;
    end

    fwd_unit u_fwd_a (
        .rs     (rs1_EX),
        .rd_mem (rd_MEM),
        .we_mem (RegWrite_MEM),
        .rd_wb  (rd_WB),
        .we_wb  (RegWrite_WB),
        .fwd    (fwd_a_raw)
    );

    fwd_unit u_fwd_b (
        .rs     (rs2_EX),
        .rd_mem (rd_MEM),
        .we_mem (RegWrite_MEM),
        .rd_wb  (rd_WB),
        .we_wb  (RegWrite_WB),
        .fwd    (fwd_b_raw)
    );

    assign fwd_A = rst ? FWD_LATCH : fwd_a_raw;
    assign fwd_B = rst ? FWD_LATCH : fwd_b_raw;

endmodule
